// File: rtl/if_id_skid_stage.sv
// IF/ID boundary register with valid/ready handshakes, a two-entry skid buffer,
// flush, NOP bubble insertion and a saturating stall-cycle counter.
module if_id_skid_stage #(
  parameter int unsigned       XLEN      = 32,
  parameter int unsigned       ILEN      = 32,
  parameter logic [ILEN-1:0]   NOP_INSTR = 32'h00000013,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc_next,
  input  logic [ILEN-1:0]  in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc_next,
  output logic [ILEN-1:0]  out_instr,
  output logic [1:0]       occupancy,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q,     state_d;
  logic [XLEN-1:0]  main_pc_q,   main_pc_d;
  logic [ILEN-1:0]  main_instr_q, main_instr_d;
  logic [XLEN-1:0]  skid_pc_q,   skid_pc_d;
  logic [ILEN-1:0]  skid_instr_q, skid_instr_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q,  in_ready_d;
  logic [1:0]       occ_q,       occ_d;
  logic [CNT_W-1:0] stall_q,     stall_d;

  logic accept;
  logic drain;

  // Handshakes use only registered state on our side, so in_ready never sees out_ready.
  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  // Next-state and datapath. Main fields are kept at 0/NOP whenever main is empty,
  // so the output ports can be driven straight from flops.
  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (flush) begin
      state_d      = ST_EMPTY;
      main_pc_d    = {XLEN{1'b0}};
      main_instr_d = NOP_INSTR;
      skid_pc_d    = {XLEN{1'b0}};
      skid_instr_d = NOP_INSTR;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d      = ST_ONE;
            main_pc_d    = in_pc_next;
            main_instr_d = in_instr;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_pc_d    = in_pc_next;
            main_instr_d = in_instr;
          end else if (accept) begin
            state_d      = ST_FULL;
            skid_pc_d    = in_pc_next;
            skid_instr_d = in_instr;
          end else if (drain) begin
            state_d      = ST_EMPTY;
            main_pc_d    = {XLEN{1'b0}};
            main_instr_d = NOP_INSTR;
          end else begin
            state_d      = ST_ONE;
          end
        end
        ST_FULL: begin
          if (drain) begin
            state_d      = ST_ONE;
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
            skid_pc_d    = {XLEN{1'b0}};
            skid_instr_d = NOP_INSTR;
          end else begin
            state_d      = ST_FULL;
          end
        end
        default: begin
          state_d      = ST_EMPTY;
          main_pc_d    = {XLEN{1'b0}};
          main_instr_d = NOP_INSTR;
          skid_pc_d    = {XLEN{1'b0}};
          skid_instr_d = NOP_INSTR;
        end
      endcase
    end

    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
    case (state_d)
      ST_ONE:  occ_d = 2'd1;
      ST_FULL: occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

  // Stall counter: clear beats increment; saturate rather than wrap.
  always_comb begin
    stall_d = stall_q;
    if (clr_stats) begin
      stall_d = {CNT_W{1'b0}};
    end else if (out_valid_q && !out_ready && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_d = stall_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      main_pc_q    <= {XLEN{1'b0}};
      main_instr_q <= NOP_INSTR;
      skid_pc_q    <= {XLEN{1'b0}};
      skid_instr_q <= NOP_INSTR;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      occ_q        <= 2'd0;
      stall_q      <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      occ_q        <= occ_d;
      stall_q      <= stall_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_pc_next = main_pc_q;
  assign out_instr   = main_instr_q;
  assign occupancy   = occ_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed self-checking bench for if_id_skid_stage (built with CNT_W=4 so
// saturation is reachable in a few cycles).
module tb_if_id_skid_stage;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned CNT_W = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, flush, out_valid, out_ready, clr_stats;
  logic [XLEN-1:0]  in_pc_next, out_pc_next;
  logic [ILEN-1:0]  in_instr, out_instr;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_count;

  int tests  = 0;
  int failed = 0;

  if_id_skid_stage #(.XLEN(XLEN), .ILEN(ILEN), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc_next(in_pc_next), .in_instr(in_instr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc_next(out_pc_next),
    .out_instr(out_instr), .occupancy(occupancy), .clr_stats(clr_stats),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled and inputs changed 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid   = v;
    in_instr   = instr;
    in_pc_next = pc;
  endtask

  // Compact snapshot: {out_valid, in_ready, occupancy, stall_count, out_instr, out_pc_next}
  function automatic logic [73:0] snap();
    return {out_valid, in_ready, occupancy, stall_count, out_instr, out_pc_next};
  endfunction

  function automatic logic [73:0] mk(input logic v, input logic r, input logic [1:0] o,
                                     input logic [3:0] s, input logic [31:0] i,
                                     input logic [31:0] p);
    return {v, r, o, s, i, p};
  endfunction

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; clr_stats = 1'b0; out_ready = 1'b0;
    beat(1'b1, 32'hDEADBEEF, 32'h00000040);
    step();
    tests++;
    if (in_ready !== 1'b1) begin
      failed++; $display("FAIL reset_in_ready_first_edge got %b want 1", in_ready);
    end
    step();
    reset = 1'b0; beat(1'b0, 32'h0, 32'h0);
    tests++;
    if (snap() !== mk(1'b0, 1'b1, 2'd0, 4'd0, NOP, 32'd0)) begin
      failed++; $display("FAIL reset_state got %h want %h", snap(), mk(1'b0, 1'b1, 2'd0, 4'd0, NOP, 32'd0));
    end
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      failed++; $display("FAIL reset_beat_discarded got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_stream();
    logic [31:0] ins [3];
    ins[0] = 32'h00A00093; ins[1] = 32'h00108113; ins[2] = 32'h00210193;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, ins[i], 32'(4 * (i + 1)));
      step();
      tests++;
      if (snap() !== mk(1'b1, 1'b1, 2'd1, 4'd0, ins[i], 32'(4 * (i + 1)))) begin
        failed++; $display("FAIL stream_%0d got %h want %h", i, snap(), mk(1'b1, 1'b1, 2'd1, 4'd0, ins[i], 32'(4 * (i + 1))));
      end
    end
    beat(1'b0, 32'h0, 32'h0);
    step();
    tests++;
    if (snap() !== mk(1'b0, 1'b1, 2'd0, 4'd0, NOP, 32'd0)) begin
      failed++; $display("FAIL stream_drain_bubble got %h want %h", snap(), mk(1'b0, 1'b1, 2'd0, 4'd0, NOP, 32'd0));
    end
  endtask

  task automatic test_backpressure();
    logic [73:0] exp [6];
    exp[0] = mk(1'b1, 1'b1, 2'd1, 4'd0, 32'hA0000001, 32'h10);
    exp[1] = mk(1'b1, 1'b0, 2'd2, 4'd1, 32'hA0000001, 32'h10);
    exp[2] = mk(1'b1, 1'b0, 2'd2, 4'd2, 32'hA0000001, 32'h10);
    exp[3] = mk(1'b1, 1'b1, 2'd1, 4'd2, 32'hA0000002, 32'h14);
    exp[4] = mk(1'b1, 1'b1, 2'd1, 4'd2, 32'hA0000003, 32'h18);
    exp[5] = mk(1'b0, 1'b1, 2'd0, 4'd2, NOP, 32'd0);
    out_ready = 1'b0;
    beat(1'b1, 32'hA0000001, 32'h10);
    for (int c = 0; c < 6; c++) begin
      step();
      tests++;
      if (snap() !== exp[c]) begin
        failed++; $display("FAIL backpressure_cycle%0d got %h want %h", c, snap(), exp[c]);
      end
      case (c)
        0: beat(1'b1, 32'hA0000002, 32'h14);
        1: beat(1'b1, 32'hA0000003, 32'h18);
        2: out_ready = 1'b1;
        4: beat(1'b0, 32'h0, 32'h0);
        default: ;
      endcase
    end
  endtask

  task automatic test_flush();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    out_ready = 1'b0;
    beat(1'b1, 32'hB0000001, 32'h20);
    step();
    beat(1'b1, 32'hB0000002, 32'h24);
    step();
    tests++;
    if (snap() !== mk(1'b1, 1'b0, 2'd2, 4'd1, 32'hB0000001, 32'h20)) begin
      failed++; $display("FAIL flush_setup_full got %h want %h", snap(), mk(1'b1, 1'b0, 2'd2, 4'd1, 32'hB0000001, 32'h20));
    end
    flush = 1'b1;
    beat(1'b1, 32'hB0000003, 32'h28);
    step();
    flush = 1'b0;
    tests++;
    if (snap() !== mk(1'b0, 1'b1, 2'd0, 4'd2, NOP, 32'd0)) begin
      failed++; $display("FAIL flush_full got %h want %h", snap(), mk(1'b0, 1'b1, 2'd0, 4'd2, NOP, 32'd0));
    end
    beat(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      failed++; $display("FAIL flush_incoming_never_seen got out_valid=%b instr=%h want 0", out_valid, out_instr);
    end
    beat(1'b1, 32'hB0000004, 32'h2C);
    step();
    flush = 1'b1;
    beat(1'b1, 32'hB0000005, 32'h30);
    step();
    flush = 1'b0;
    beat(1'b0, 32'h0, 32'h0);
    tests++;
    if (snap() !== mk(1'b0, 1'b1, 2'd0, 4'd2, NOP, 32'd0)) begin
      failed++; $display("FAIL flush_accept_dropped got %h want %h", snap(), mk(1'b0, 1'b1, 2'd0, 4'd2, NOP, 32'd0));
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      beat(1'b1, 32'h10000000 + 32'(i), 32'h100 + 32'(4 * i));
      step();
      tests++;
      if (snap() !== mk(1'b1, 1'b1, 2'd1, 4'd2, 32'h10000000 + 32'(i), 32'h100 + 32'(4 * i))) begin
        failed++; $display("FAIL back_to_back_%0d got %h want %h", i, snap(), mk(1'b1, 1'b1, 2'd1, 4'd2, 32'h10000000 + 32'(i), 32'h100 + 32'(4 * i)));
      end
    end
    beat(1'b0, 32'h0, 32'h0);
    step();
    tests++;
    if (occupancy !== 2'd0) begin
      failed++; $display("FAIL back_to_back_empty got %0d want 0", occupancy);
    end
  endtask

  task automatic test_stall_saturation();
    out_ready = 1'b0;
    beat(1'b1, 32'hC0000001, 32'h40);
    step();
    beat(1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 20; c++) step();
    tests++;
    if (stall_count !== 4'd15) begin
      failed++; $display("FAIL stall_saturate got %0d want 15", stall_count);
    end
    tests++;
    if ({out_valid, out_instr} !== {1'b1, 32'hC0000001}) begin
      failed++; $display("FAIL stall_output_hold got %b/%h want 1/c0000001", out_valid, out_instr);
    end
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    tests++;
    if (stall_count !== 4'd0) begin
      failed++; $display("FAIL stall_clear got %0d want 0", stall_count);
    end
    step();
    tests++;
    if (stall_count !== 4'd1) begin
      failed++; $display("FAIL stall_restart got %0d want 1", stall_count);
    end
  endtask

  task automatic test_reset_midop();
    beat(1'b1, 32'hD0000001, 32'h50);
    step();
    tests++;
    if (occupancy !== 2'd2) begin
      failed++; $display("FAIL midop_full got %0d want 2", occupancy);
    end
    reset = 1'b1;
    beat(1'b1, 32'hD0000002, 32'h54);
    step();
    tests++;
    if (snap() !== mk(1'b0, 1'b1, 2'd0, 4'd0, NOP, 32'd0)) begin
      failed++; $display("FAIL midop_reset got %h want %h", snap(), mk(1'b0, 1'b1, 2'd0, 4'd0, NOP, 32'd0));
    end
    beat(1'b1, 32'hD0000003, 32'h58);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    beat(1'b0, 32'h0, 32'h0);
    step();
    tests++;
    if (snap() !== mk(1'b0, 1'b1, 2'd0, 4'd0, NOP, 32'd0)) begin
      failed++; $display("FAIL midop_after_reset got %h want %h", snap(), mk(1'b0, 1'b1, 2'd0, 4'd0, NOP, 32'd0));
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pc_next = 32'h0;
    flush = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_stall_saturation();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
